// File: rtl/router_rr_scheduler.sv
// router_rr_scheduler: packet-level round-robin scheduler that shares one output
// lane FIFO among four input lane FIFOs. A whole packet of NUMBER_PACKET beats is
// moved from the granted input before ownership can change. The hop-count field of
// each header beat is decremented on the way through and saturates at zero.
// Optional feature macro: ROUTER_SCHED_STATS_EN adds per-input packet counters
// (pkt_count) and a synchronous counter clear (stats_clr).
module router_rr_scheduler #(
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int NUMBER_PACKET     = 5,
  parameter int HOP_LSB           = 5,
  parameter int HOP_WIDTH         = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     in_empty,
  output logic [3:0]                     in_rd,
  input  logic [4*AURORA_DATA_WIDTH-1:0] in_data,
  input  logic                           out_full,
  output logic                           out_we,
  output logic [AURORA_DATA_WIDTH-1:0]   out_data,
  output logic [1:0]                     grant,
  output logic                           busy
`ifdef ROUTER_SCHED_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [63:0]                    pkt_count
`endif
);

  localparam int CNT_W = $clog2(NUMBER_PACKET);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rr_ptr;
  logic [1:0]       winner;
  logic [CNT_W-1:0] beat_cnt;
  logic [3:0]       req;
  logic             last_write;
  logic [AURORA_DATA_WIDTH-1:0] lane_data;

  // Decrement the hop field of a header beat; a zero hop count is left untouched.
  function automatic logic [AURORA_DATA_WIDTH-1:0] hop_decrement(
    input logic [AURORA_DATA_WIDTH-1:0] beat
  );
    logic [AURORA_DATA_WIDTH-1:0] res;
    logic [HOP_WIDTH-1:0]         hop;
    res = beat;
    hop = beat[HOP_LSB +: HOP_WIDTH];
    if (hop != '0) begin
      res[HOP_LSB +: HOP_WIDTH] = hop - 1'b1;
    end
    return res;
  endfunction

  assign req        = ~in_empty;
  assign last_write = (state == WRITE) && (beat_cnt == LAST_BEAT);
  assign busy       = (state != IDLE);

  // Round-robin search: first requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic with Moore strobes decoded from the registered state and grant.
  always_comb begin
    state_nxt = state;
    in_rd     = '0;
    out_we    = 1'b0;
    case (state)
      IDLE: begin
        if (|req && !out_full) begin
          state_nxt = READ;
        end
      end
      READ: begin
        in_rd[grant] = 1'b1;
        state_nxt    = WRITE;
      end
      WRITE: begin
        out_we = 1'b1;
        if (beat_cnt == LAST_BEAT) begin
          state_nxt = IDLE;
        end else if (req[grant] && !out_full) begin
          state_nxt = READ;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (req[grant] && !out_full) begin
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, beat counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == READ) begin
        grant    <= winner;
        beat_cnt <= '0;
      end
      if (state == WRITE) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          rr_ptr   <= grant + 2'd1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Output data is the granted lane, with the hop field adjusted on the header beat.
  always_comb begin
    lane_data = in_data[grant*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH];
    out_data  = lane_data;
    if (state == WRITE && beat_cnt == '0) begin
      out_data = hop_decrement(lane_data);
    end
  end

`ifdef ROUTER_SCHED_STATS_EN
  logic [15:0] pkt_cnt [4];

  // Per-input completed-packet counters; clear has priority, counts saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
    end else if (last_write && pkt_cnt[grant] != 16'hFFFF) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + 16'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign pkt_count[g*16 +: 16] = pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_router_rr_scheduler.sv
// Testbench for router_rr_scheduler: input FIFOs held as arrays in the bench,
// a packet-level model of round-robin ownership and header hop handling, and
// directed scenarios with literal expectations. Also builds with
// ROUTER_SCHED_STATS_EN defined to exercise the packet counters.
module tb_router_rr_scheduler;
  localparam int W  = 256;
  localparam int NP = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_empty;
  logic [3:0]   in_rd;
  logic [4*W-1:0] in_data;
  logic         out_full;
  logic         out_we;
  logic [W-1:0] out_data;
  logic [1:0]   grant;
  logic         busy;
`ifdef ROUTER_SCHED_STATS_EN
  logic         stats_clr;
  logic [63:0]  pkt_count;
`endif

  router_rr_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_empty (in_empty),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .out_full (out_full),
    .out_we   (out_we),
    .out_data (out_data),
    .grant    (grant),
    .busy     (busy)
`ifdef ROUTER_SCHED_STATS_EN
    ,
    .stats_clr(stats_clr),
    .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Input FIFO storage: written by the stimulus, popped on in_rd.
  logic [W-1:0] fmem [4][64];
  int wp [4];
  int rp [4];

  // Model state: expected read pointers, packet bookkeeping, round-robin pointer.
  int mrp [4];
  int loaded [4];
  int done [4];
  int pid [4];
  int m_rr = 0;
  int beat_idx = 0;
  int cur = 0;
  int wr_count = 0;
  int pkt_done_cnt = 0;
  int gq [$];

  always_comb begin
    for (int i = 0; i < 4; i++) in_empty[i] = (wp[i] == rp[i]);
  end

  // Input FIFO read port: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_rd[i]) begin
        in_data[i*W +: W] <= fmem[i][rp[i] % 64];
        rp[i] <= rp[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input int i, input int p, input int b, input logic [1:0] hop);
    logic [31:0] w;
    logic [W-1:0] v;
    w = 32'h9E37_0000 + 32'(i*4096 + p*64 + b);
    v = {8{w}};
    if (b == 0) v[6:5] = hop;
    return v;
  endfunction

  // Header rule: a nonzero hop count goes down by one, zero stays zero.
  function automatic logic [W-1:0] hop_model(input logic [W-1:0] v);
    int h;
    h = int'((v >> 5) & 256'd3);
    if (h > 0) return v - (256'd1 << 5);
    return v;
  endfunction

  function automatic int pick(input int r);
    for (int k = 0; k < 4; k++) begin
      if (loaded[(r + k) % 4] > done[(r + k) % 4]) return (r + k) % 4;
    end
    return -1;
  endfunction

  task automatic push(input int i, input logic [W-1:0] v);
    fmem[i][wp[i] % 64] = v;
    wp[i] = wp[i] + 1;
  endtask

  task automatic load_pkt(input int i, input logic [1:0] hop);
    for (int b = 0; b < NP; b++) push(i, mk_beat(i, pid[i], b, hop));
    pid[i]++;
    loaded[i]++;
  endtask

  // Per-cycle comparison of the DUT against the packet-level model.
  task automatic compare_cycle();
    logic [W-1:0] exp;
    if (!rst_n) return;
    if (in_rd != 4'b0000) begin
      chk("rd_onehot", W'($onehot(in_rd)), W'(1));
      chk("rd_not_empty", W'(in_rd & in_empty), W'(0));
    end
    if (out_we) begin
      chk("we_while_full", W'(out_full), W'(0));
      if (beat_idx == 0) begin
        cur = pick(m_rr);
        if (cur < 0) begin
          chk("unexpected_write", W'(out_we), W'(0));
          return;
        end
        gq.push_back(int'(grant));
      end
      exp = fmem[cur][mrp[cur] % 64];
      mrp[cur]++;
      if (beat_idx == 0) exp = hop_model(exp);
      chk("grant", W'(grant), W'(cur));
      chk("out_data", out_data, exp);
      wr_count++;
      beat_idx++;
      if (beat_idx == NP) begin
        beat_idx = 0;
        done[cur]++;
        m_rr = (cur + 1) % 4;
        pkt_done_cnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkt_done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("pkt_timeout", W'(pkt_done_cnt >= target), W'(1));
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      step();
      n++;
    end
    chk("write_timeout", W'(wr_count >= target), W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{3, 0, 1, 2, 0};
    int base;
    logic [W-1:0] hdr;
    rst_n    = 1'b0;
    out_full = 1'b0;
`ifdef ROUTER_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_rd", W'(in_rd), W'(0));
    chk("rst_out_we", W'(out_we), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_grant", W'(grant), W'(0));
    rst_n = 1'b1;

    // All inputs empty: scheduler stays idle.
    repeat (20) begin
      step();
      chk("idle_in_rd", W'(in_rd), W'(0));
      chk("idle_out_we", W'(out_we), W'(0));
      chk("idle_busy", W'(busy), W'(0));
    end

    // Single packet on input 2 with hop 3.
    load_pkt(2, 2'b11);
    step();
    chk("t2_read", W'(in_rd), W'(4'b0100));
    chk("t2_we_early", W'(out_we), W'(0));
    step();
    chk("t2_first_we", W'(out_we), W'(1));
    chk("t2_hop", W'(out_data[6:5]), W'(2'b10));
    chk("t2_hdr", out_data, mk_beat(2, 0, 0, 2'b10));
    chk("t2_grant", W'(grant), W'(2));
    wait_pkts(1, 40);
    chk("t2_beats", W'(wr_count), W'(5));
    step();
    chk("t2_idle", W'(busy), W'(0));

    // Every input requesting; rr_ptr is 3 after the previous packet.
    gq.delete();
    load_pkt(0, 2'b01);
    load_pkt(0, 2'b10);
    load_pkt(1, 2'b11);
    load_pkt(2, 2'b01);
    load_pkt(3, 2'b00);
    wait_pkts(6, 200);
    chk("t3_count", W'(gq.size()), W'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < gq.size()) chk("t3_order", W'(gq[k]), W'(exp_order[k]));
    end
    step();

    // Input 1 runs dry after two beats, then the output is full for 10 cycles.
    base = wr_count;
    push(1, mk_beat(1, pid[1], 0, 2'b01));
    push(1, mk_beat(1, pid[1], 1, 2'b00));
    loaded[1]++;
    wait_writes(base + 2, 20);
    step();
    out_full = 1'b1;
    for (int b = 2; b < NP; b++) push(1, mk_beat(1, pid[1], b, 2'b00));
    pid[1]++;
    repeat (10) begin
      step();
      chk("hold_no_we", W'(out_we), W'(0));
      chk("hold_no_rd", W'(in_rd), W'(0));
      chk("hold_busy", W'(busy), W'(1));
    end
    out_full = 1'b0;
    wait_pkts(7, 40);
    chk("t4_beats", W'(wr_count - base), W'(5));
    step();

    // Zero hop count passes through unchanged.
    hdr = mk_beat(2, pid[2], 0, 2'b00);
    load_pkt(2, 2'b00);
    step();
    step();
    chk("t5_hdr", out_data, hdr);
    chk("t5_grant", W'(grant), W'(2));
    wait_pkts(8, 40);
    step();

    // Reset in the middle of a packet from input 3.
    base = wr_count;
    load_pkt(3, 2'b10);
    wait_writes(base + 3, 30);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_rd", W'(in_rd), W'(0));
    chk("midrst_out_we", W'(out_we), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    for (int i = 0; i < 4; i++) begin
      wp[i] = rp[i];
      mrp[i] = rp[i];
      loaded[i] = 0;
      done[i] = 0;
    end
    m_rr = 0;
    beat_idx = 0;
    step();
    step();
    chk("midrst_grant", W'(grant), W'(0));
    rst_n = 1'b1;
    step();
    base = pkt_done_cnt;
    gq.delete();
    load_pkt(1, 2'b01);
    load_pkt(3, 2'b11);
    wait_pkts(base + 2, 60);
    chk("t6_count", W'(gq.size()), W'(2));
    if (gq.size() == 2) begin
      chk("t6_first", W'(gq[0]), W'(1));
      chk("t6_second", W'(gq[1]), W'(3));
    end
    step();

`ifdef ROUTER_SCHED_STATS_EN
    // Packet counters: clear, three packets from input 1, clear again.
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr0", W'(pkt_count), W'(0));
    base = pkt_done_cnt;
    load_pkt(1, 2'b10);
    load_pkt(1, 2'b01);
    load_pkt(1, 2'b00);
    wait_pkts(base + 3, 100);
    step();
    chk("stats_in1", W'(pkt_count[31:16]), W'(3));
    chk("stats_in3", W'(pkt_count[63:48]), W'(0));
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr1", W'(pkt_count), W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
